fp_to_int: RTL and testbench

Sequential converter from IEEE-754 single-precision to signed 32-bit two's-complement integer. It is the decoding counterpart of the single-precision arithmetic path: it unpacks sign/exponent/mantissa and aligns the mantissa one bit per cycle. It sits behind the FP adder result bus as the float-to-integer stage. Valid/ready handshake on both sides; one conversion in flight.

---
 rtl/fp_to_int.sv | 175 +++++++++++++++++
 tb/tb_fp_to_int.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_to_int.sv
// fp_to_int: IEEE-754 single to signed 32-bit integer, one alignment bit per cycle.
// Optional build macro FP_TO_INT_RNE_EN selects round-to-nearest-even (default truncates).
`default_nettype none

module fp_to_int (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_overflow,
    output logic        out_invalid,
    output logic        out_inexact
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_ovf;
    logic        r_out_inv;
    logic        r_out_inx;
    logic        r_sign;
    logic        r_left;
    logic [4:0]  r_cnt;
    logic [31:0] r_mag;
    logic        r_guard;
    logic        r_sticky;
    logic        r_inexact;
    logic        r_special;
    logic [31:0] r_spec_data;
    logic        r_spec_ovf;
    logic        r_spec_inv;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_special;
    logic        w_nan;
    logic        w_minint;
    logic        w_left;
    logic [4:0]  w_n;
    logic [31:0] w_spec_data;
    logic        w_spec_ovf;
    logic        w_inc;
    logic [31:0] w_result;

    assign w_sign    = in_data[31];
    assign w_exp     = in_data[30:23];
    assign w_frac    = in_data[22:0];
    // exp >= 158 means unbiased exponent >= 31: never representable except -2^31
    assign w_special = (w_exp >= 8'd158);
    assign w_nan     = (w_exp == 8'hFF) && (w_frac != 23'd0);
    assign w_minint  = w_sign && (w_exp == 8'd158) && (w_frac == 23'd0);
    assign w_left    = (w_exp >= 8'd150);

    always_comb begin
        w_n = 5'd0;
        if (w_special)
            w_n = 5'd0;
        else if (w_left)
            w_n = 5'(w_exp - 8'd150);
        else if (w_exp >= 8'd125)
            w_n = 5'(8'd150 - w_exp);
        else
            w_n = 5'd25;
    end

    assign w_spec_data = (w_nan || w_minint || w_sign) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    assign w_spec_ovf  = w_special && !w_nan && !w_minint;

`ifdef FP_TO_INT_RNE_EN
    assign w_inc = r_guard & (r_sticky | r_mag[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign w_result = r_special ? r_spec_data : (r_sign ? (32'd0 - r_mag) : r_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_ovf   <= 1'b0;
            r_out_inv   <= 1'b0;
            r_out_inx   <= 1'b0;
            r_sign      <= 1'b0;
            r_left      <= 1'b0;
            r_cnt       <= 5'd0;
            r_mag       <= 32'd0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_inexact   <= 1'b0;
            r_special   <= 1'b0;
            r_spec_data <= 32'd0;
            r_spec_ovf  <= 1'b0;
            r_spec_inv  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready  <= 1'b0;
                        r_sign      <= w_sign;
                        r_left      <= w_left;
                        r_cnt       <= w_n;
                        r_mag       <= {8'd0, (w_exp != 8'd0), w_frac};
                        r_guard     <= 1'b0;
                        r_sticky    <= 1'b0;
                        r_special   <= w_special;
                        r_spec_data <= w_spec_data;
                        r_spec_ovf  <= w_spec_ovf;
                        r_spec_inv  <= w_nan;
                        r_state     <= (w_n != 5'd0) ? S_SHIFT : S_ROUND;
                    end else begin
                        r_in_ready  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_left) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                    end else begin
                        r_mag    <= {1'b0, r_mag[31:1]};
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1)
                        r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_mag     <= r_mag + {31'd0, w_inc};
                    r_inexact <= r_guard | r_sticky;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle publishes the signed result; later cycles hold it
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                        r_out_ovf   <= r_spec_ovf;
                        r_out_inv   <= r_spec_inv;
                        r_out_inx   <= r_inexact & ~r_special;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_overflow = r_out_ovf;
    assign out_invalid  = r_out_inv;
    assign out_inexact  = r_out_inx;

endmodule

`default_nettype wire

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: directed vectors with hand-computed results, latencies and flags.
`default_nettype none

module tb_fp_to_int;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_overflow;
    logic        out_invalid;
    logic        out_inexact;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FP_TO_INT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    fp_to_int dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_invalid  (out_invalid),
        .out_inexact  (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    // Present an operand and return #1 after the handshake edge
    task automatic launch(input string tag, input logic [31:0] a);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic conv(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic [2:0] exp_flags, input int lat, input int hold);
        int k;
        logic [31:0] held;
        launch(tag, a);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 40);
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_flags"}, {29'd0, out_overflow, out_invalid, out_inexact}, {29'd0, exp_flags});
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, {out_data[31:1], out_data[0] ^ ~out_valid}, {held[31:1], held[0]});
            chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_acc"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #2;
        chk("rst_outs", {out_data[31:4], out_valid, out_overflow, out_invalid, out_inexact}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready0", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready1", {31'd0, in_ready}, 32'd1);

        // flags are {overflow, invalid, inexact}
        conv("pi",     32'h40490FDB, 32'h0000_0003, 3'b001, 24, 0);
        conv("one_p5", 32'h3FC00000, RNE ? 32'd2 : 32'd1, 3'b001, 25, 0);
        conv("two_p5", 32'h40200000, 32'd2, 3'b001, 24, 0);
        conv("m1_p5",  32'hBFC00000, RNE ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 3'b001, 25, 0);
        conv("p0_75",  32'h3F400000, RNE ? 32'd1 : 32'd0, 3'b001, 26, 0);
        conv("m123",   32'hC2F60000, 32'hFFFF_FF85, 3'b000, 19, 0);
        conv("maxpos", 32'h4EFFFFFF, 32'h7FFF_FF80, 3'b000, 9, 0);
        conv("minint", 32'hCF000000, 32'h8000_0000, 3'b000, 2, 0);
        conv("p2_31",  32'h4F000000, 32'h7FFF_FFFF, 3'b100, 2, 0);
        conv("ninf",   32'hFF800000, 32'h8000_0000, 3'b100, 2, 0);
        conv("nan",    32'h7FC00000, 32'h8000_0000, 3'b010, 2, 0);
        conv("denorm", 32'h00000001, 32'h0000_0000, 3'b001, 27, 0);
        conv("lsh1",   32'h4B800001, 32'h0100_0002, 3'b000, 3, 5);

        launch("abort", 32'h3F800000);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_data", out_data, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel0", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_rel1", {31'd0, in_ready}, 32'd1);
        conv("one",    32'h3F800000, 32'd1, 3'b000, 25, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
